ex_stage: RTL

- Execute stage of the 5-stage RV64I pipeline, directly downstream of the ID/EX register.
- Consumes ID/EX stored outputs, forwards operands, performs the ALU operation and resolves branches.
- Captures results into an internal EX/MEM register.
- Generates the branch-taken flush that squashes IF/ID, ID/EX and the wrong-path instruction currently in EX.

---
 rtl/ex_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage of the RV64I pipeline: operand forwarding, ALU, branch resolution
// and the EX/MEM register, which also generates the single-cycle branch flush.
module ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_addr,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] imm_val,
    input  logic [3:0]      funct_in,
    input  logic [4:0]      rd_in,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    input  logic            Branch,
    input  logic            MemWrite,
    input  logic            MemRead,
    input  logic            ALUSrc,
    input  logic [1:0]      ALU_op,
    input  logic [4:0]      wb_rd,
    input  logic            wb_RegWrite,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_result_store,
    output logic [XLEN-1:0] write_data_store,
    output logic [4:0]      rd_store,
    output logic            MemtoReg_store,
    output logic            RegWrite_store,
    output logic            MemWrite_store,
    output logic            MemRead_store,
    output logic [XLEN-1:0] branch_target_store,
    output logic            PCSrc_store,
    output logic            flush_out
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_alu;
    logic [3:0]      w_funct;
    logic [SHW-1:0]  w_shamt;
    logic            w_ex_ok;
    logic            w_wb_ok;
    logic            w_slt;
    logic            w_sltu;
    logic            w_blt;
    logic            w_bltu;
    logic            w_cond;
    logic            w_taken;

    // A load in EX/MEM has no value yet; load-use is stalled upstream.
    assign w_ex_ok = RegWrite_store && (rd_store != 5'd0) && !MemtoReg_store;
    assign w_wb_ok = wb_RegWrite && (wb_rd != 5'd0);

    // Operand A forwarding, EX/MEM before MEM/WB.
    always_comb begin
        if (w_ex_ok && (rd_store == rs1_in)) begin
            w_fwd_a = alu_result_store;
        end else if (w_wb_ok && (wb_rd == rs1_in)) begin
            w_fwd_a = wb_data;
        end else begin
            w_fwd_a = read_data1;
        end
    end

    // Operand rs2 forwarding, EX/MEM before MEM/WB.
    always_comb begin
        if (w_ex_ok && (rd_store == rs2_in)) begin
            w_fwd_b = alu_result_store;
        end else if (w_wb_ok && (wb_rd == rs2_in)) begin
            w_fwd_b = wb_data;
        end else begin
            w_fwd_b = read_data2;
        end
    end

    assign w_op_b  = ALUSrc ? imm_val : w_fwd_b;
    assign w_diff  = w_fwd_a - w_op_b;
    assign w_shamt = w_op_b[SHW-1:0];
    assign w_slt   = $signed(w_fwd_a) < $signed(w_op_b);
    assign w_sltu  = w_fwd_a < w_op_b;
    assign w_blt   = $signed(w_fwd_a) < $signed(w_fwd_b);
    assign w_bltu  = w_fwd_a < w_fwd_b;
    // For immediates, instr[30] is part of the immediate except on SRAI.
    assign w_funct = {funct_in[3] & (!ALUSrc || (funct_in[2:0] == 3'b101)), funct_in[2:0]};

    // ALU result selection.
    always_comb begin
        w_alu = {XLEN{1'b0}};
        case (ALU_op)
            2'b00: w_alu = w_fwd_a + w_op_b;
            2'b01: w_alu = w_diff;
            2'b10: begin
                case (w_funct)
                    4'b0000: w_alu = w_fwd_a + w_op_b;
                    4'b1000: w_alu = w_diff;
                    4'b0111: w_alu = w_fwd_a & w_op_b;
                    4'b0110: w_alu = w_fwd_a | w_op_b;
                    4'b0100: w_alu = w_fwd_a ^ w_op_b;
                    4'b0001: w_alu = w_fwd_a << w_shamt;
                    4'b0101: w_alu = w_fwd_a >> w_shamt;
                    4'b1101: w_alu = $unsigned($signed(w_fwd_a) >>> w_shamt);
                    4'b0010: w_alu = {{(XLEN-1){1'b0}}, w_slt};
                    4'b0011: w_alu = {{(XLEN-1){1'b0}}, w_sltu};
                    default: w_alu = {XLEN{1'b0}};
                endcase
            end
            default: w_alu = {XLEN{1'b0}};
        endcase
    end

    // Branch condition on funct3, comparing against rs2 rather than operand B.
    always_comb begin
        w_cond = 1'b0;
        case (funct_in[2:0])
            3'b000:  w_cond = (w_fwd_a == w_fwd_b);
            3'b001:  w_cond = (w_fwd_a != w_fwd_b);
            3'b100:  w_cond = w_blt;
            3'b101:  w_cond = !w_blt;
            3'b110:  w_cond = w_bltu;
            3'b111:  w_cond = !w_bltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken = Branch && w_cond;

    // EX/MEM register; a taken branch turns the next capture into a bubble.
    always_ff @(posedge clk) begin
        if (reset || PCSrc_store) begin
            alu_result_store    <= {XLEN{1'b0}};
            write_data_store    <= {XLEN{1'b0}};
            rd_store            <= 5'd0;
            MemtoReg_store      <= 1'b0;
            RegWrite_store      <= 1'b0;
            MemWrite_store      <= 1'b0;
            MemRead_store       <= 1'b0;
            branch_target_store <= {XLEN{1'b0}};
            PCSrc_store         <= 1'b0;
        end else begin
            alu_result_store    <= w_alu;
            write_data_store    <= w_fwd_b;
            rd_store            <= rd_in;
            MemtoReg_store      <= MemtoReg;
            RegWrite_store      <= RegWrite;
            MemWrite_store      <= MemWrite;
            MemRead_store       <= MemRead;
            branch_target_store <= PC_addr + imm_val;
            PCSrc_store         <= w_taken;
        end
    end

    assign flush_out = PCSrc_store;

endmodule
